// File: rtl/branch_fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers fetched words into IF/ID,
// redirects on taken EX branches (two-slot squash) and honours load-use stalls.
module branch_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [12:0] ex_imm_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        id_ex_flush_o,
  output logic        misaligned_o,
  output logic [31:0] taken_count_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] taken_count_q, taken_count_d;
  logic [31:0] target_s;

  // Redirect target: modular add of the sign-extended B-immediate.
  always_comb begin
    target_s = ex_pc_i + {{19{ex_imm_i[12]}}, ex_imm_i};
  end

  // Next-state selection: redirect beats stall, stall beats normal fetch.
  always_comb begin
    state_d       = ST_RUN;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    misaligned_d  = misaligned_q;
    taken_count_d = taken_count_q;
    if (branch_taken_i) begin
      state_d       = ST_FLUSH;
      pc_d          = {target_s[31:2], 2'b00};
      if_id_pc_d    = 32'h0000_0000;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      misaligned_d  = misaligned_q | (target_s[1:0] != 2'b00);
      taken_count_d = taken_count_q + 32'd1;
    end else if (stall_i) begin
      state_d = ST_RUN;
    end else begin
      state_d       = ST_RUN;
      pc_d          = pc_q + 32'd4;
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_rdata_i;
      if_id_valid_d = 1'b1;
    end
  end

  // Pipeline/state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      taken_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      misaligned_q  <= misaligned_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_valid_o = if_id_valid_q;
  assign id_ex_flush_o = (state_q == ST_FLUSH);
  assign misaligned_o  = misaligned_q;
  assign taken_count_o = taken_count_q;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Directed plus randomized bench for branch_fetch_unit against a per-edge
// behavioural model of the fetch stage.
module tb_branch_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] ex_pc;
  logic [12:0] ex_imm;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        id_ex_flush;
  logic        misaligned;
  logic [31:0] taken_count;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc, m_if_pc, m_instr, m_cnt;
  logic        m_valid, m_flush, m_mis;

  branch_fetch_unit dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .branch_taken_i (branch_taken),
    .ex_pc_i        (ex_pc),
    .ex_imm_i       (ex_imm),
    .imem_rdata_i   (imem_rdata),
    .imem_addr_o    (imem_addr),
    .if_id_pc_o     (if_id_pc),
    .if_id_instr_o  (if_id_instr),
    .if_id_valid_o  (if_id_valid),
    .id_ex_flush_o  (id_ex_flush),
    .misaligned_o   (misaligned),
    .taken_count_o  (taken_count)
  );

  always #5 clk = ~clk;

  assign imem_rdata = 32'hAAAA_0000 + imem_addr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input logic r, input logic br, input logic st,
                      input logic [31:0] epc, input logic [12:0] eimm);
    int          imm_v;
    logic [31:0] tgt;
    rst          = r;
    branch_taken = br;
    stall        = st;
    ex_pc        = epc;
    ex_imm       = eimm;
    imm_v = eimm[12] ? (int'(eimm) - 8192) : int'(eimm);
    tgt   = epc + 32'(imm_v);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h13; m_if_pc = 32'h0; m_valid = 1'b0;
      m_flush = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (br) begin
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h13; m_if_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b1;
      m_mis   = m_mis | (tgt % 4 != 0);
      m_cnt   = m_cnt + 32'd1;
    end else if (st) begin
      m_flush = 1'b0;
    end else begin
      m_instr = 32'hAAAA_0000 + m_pc;
      m_if_pc = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_flush = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("imem_addr",   imem_addr,   m_pc);
    check_val("if_id_pc",    if_id_pc,    m_if_pc);
    check_val("if_id_instr", if_id_instr, m_instr);
    check_val("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check_val("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, m_flush});
    check_val("misaligned",  {31'd0, misaligned},  {31'd0, m_mis});
    check_val("taken_count", taken_count, m_cnt);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; ex_pc = 32'h0; ex_imm = 13'h0;
    m_pc = 32'h0; m_if_pc = 32'h0; m_instr = 32'h13; m_cnt = 32'h0;
    m_valid = 1'b0; m_flush = 1'b0; m_mis = 1'b0;

    step(1'b1, 1'b0, 1'b0, 32'h0, 13'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 13'h0);
    // free run, then stall at pc=8
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 13'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0, 13'h0);
    check_val("stall_addr", imem_addr, 32'h8);
    check_val("stall_ifpc", if_id_pc, 32'h4);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 13'h0);
    check_val("resume_ifpc", if_id_pc, 32'hC);
    // backward branch -8
    step(1'b0, 1'b1, 1'b0, 32'h100, 13'h1FF8);
    check_val("br_pc", imem_addr, 32'hF8);
    check_val("br_instr", if_id_instr, 32'h13);
    check_val("br_flush", {31'd0, id_ex_flush}, 32'h1);
    check_val("br_cnt", taken_count, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 13'h0);
    check_val("flush_drop", {31'd0, id_ex_flush}, 32'h0);
    // branch with stall: redirect wins
    step(1'b0, 1'b1, 1'b1, 32'h20, 13'h0040);
    check_val("brst_pc", imem_addr, 32'h60);
    // target wrap-around, then PC increment wrap
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 13'h0020);
    check_val("wrap_tgt", imem_addr, 32'h10);
    step(1'b0, 1'b1, 1'b0, 32'h0, 13'h1FFC);
    check_val("neg_tgt", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 13'h0);
    check_val("pc_wrap", imem_addr, 32'h0);
    check_val("pc_wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    // sticky misaligned, then reset during stall
    step(1'b0, 1'b1, 1'b0, 32'h40, 13'h0002);
    check_val("mis_set", {31'd0, misaligned}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h80, 13'h0010);
    check_val("mis_sticky", {31'd0, misaligned}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h0, 13'h0);
    step(1'b1, 1'b1, 1'b1, 32'h200, 13'h0010);
    check_val("rst_cnt", taken_count, 32'h0);
    check_val("rst_pc", imem_addr, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [12:0] imm_r;
      imm_r = 13'($urandom) & 13'h1FFE;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), $urandom, imm_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
